// File: rtl/ibex_multdiv_issue_pkg.sv
// Shared types and constants for the multdiv issue controller.
package ibex_multdiv_issue_pkg;

    typedef enum logic [1:0] {
        MD_OP_MUL  = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } issue_state_e;

    // Cycles the unit spends in BUSY for each kind of operation.
    localparam int LAT_MUL  = 3;
    localparam int LAT_MULH = 4;
    localparam int LAT_DIV  = 37;
    localparam int LAT_DIV0 = 2;

    // Multiply-type operators are routed to the multiplier half of the unit.
    function automatic logic is_mult_op(md_op_e op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULH);
    endfunction

endpackage

// File: rtl/ibex_multdiv_issue_adder.sv
// Shared 33-bit adder used by the multdiv unit, with its zero flag.
module ibex_multdiv_issue_adder
    import ibex_multdiv_issue_pkg::*;
(
    input  logic [32:0] operand_a,
    input  logic [32:0] operand_b,
    output logic [33:0] adder_ext,
    output logic [31:0] adder,
    output logic        equal_to_zero
);

    // Operands arrive pre-shifted by the unit, so bit 0 of the sum is dropped.
    always_comb begin
        adder_ext     = {1'b0, operand_a} + {1'b0, operand_b};
        adder         = adder_ext[32:1];
        equal_to_zero = (adder == 32'd0);
    end

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Request/response wrapper around the fast multdiv unit: latches a request,
// drives the unit until it reports a result, then holds that result.
module ibex_multdiv_issue
    import ibex_multdiv_issue_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_operator_i,
    input  logic [1:0]       req_signed_mode_i,
    input  logic [31:0]      req_op_a_i,
    input  logic [31:0]      req_op_b_i,
    input  logic             req_data_ind_timing_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [CNT_W-1:0] busy_cycles_o,

    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output logic [1:0]       operator_o,
    output logic [1:0]       signed_mode_o,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    output logic             data_ind_timing_o,

    input  logic [32:0]      alu_operand_a_i,
    input  logic [32:0]      alu_operand_b_i,
    output logic [33:0]      alu_adder_ext_o,
    output logic [31:0]      alu_adder_o,
    output logic             equal_to_zero_o,

    output logic [67:0]      imd_val_q_o,
    input  logic [67:0]      imd_val_d_i,
    input  logic [1:0]       imd_val_we_i,

    output logic             multdiv_ready_id_o,
    input  logic [31:0]      multdiv_result_i,
    input  logic             valid_i
);

    issue_state_e     state_q, state_d;
    md_op_e           operator_q;
    logic [1:0]       signed_mode_q;
    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    logic             data_ind_timing_q;
    logic [31:0]      result_q;
    logic [CNT_W-1:0] busy_q;
    logic [33:0]      imd0_q;
    logic [33:0]      imd1_q;
    logic             accept;

    assign accept = req_valid_i & req_ready_o;

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the handshake and unit-control outputs of each state.
    always_comb begin
        state_d            = state_q;
        req_ready_o        = 1'b0;
        rsp_valid_o        = 1'b0;
        mult_en_o          = 1'b0;
        mult_sel_o         = 1'b0;
        div_en_o           = 1'b0;
        div_sel_o          = 1'b0;
        multdiv_ready_id_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                multdiv_ready_id_o = 1'b1;
                if (is_mult_op(operator_q)) begin
                    mult_en_o  = 1'b1;
                    mult_sel_o = 1'b1;
                end else begin
                    div_en_o  = 1'b1;
                    div_sel_o = 1'b1;
                end
                if (valid_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                // A new request can only slip in when the held result leaves.
                req_ready_o = rsp_ready_i;
                if (rsp_ready_i) begin
                    state_d = req_valid_i ? BUSY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields stay frozen from one accept to the next.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            operator_q        <= MD_OP_MUL;
            signed_mode_q     <= 2'b00;
            op_a_q            <= 32'd0;
            op_b_q            <= 32'd0;
            data_ind_timing_q <= 1'b0;
        end else if (accept) begin
            operator_q        <= md_op_e'(req_operator_i);
            signed_mode_q     <= req_signed_mode_i;
            op_a_q            <= req_op_a_i;
            op_b_q            <= req_op_b_i;
            data_ind_timing_q <= req_data_ind_timing_i;
        end
    end

    // Result is only taken while the unit is actually working for us.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= 32'd0;
        end else if ((state_q == BUSY) && valid_i) begin
            result_q <= multdiv_result_i;
        end
    end

    // Busy-cycle counter restarts on accept and saturates instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else if (accept) begin
            busy_q <= '0;
        end else if ((state_q == BUSY) && (busy_q != '1)) begin
            busy_q <= busy_q + 1'b1;
        end
    end

    // Upper intermediate register, written whenever the unit asks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            imd0_q <= 34'd0;
        end else if (imd_val_we_i[0]) begin
            imd0_q <= imd_val_d_i[67:34];
        end
    end

    // Lower intermediate register, independent of the upper one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            imd1_q <= 34'd0;
        end else if (imd_val_we_i[1]) begin
            imd1_q <= imd_val_d_i[33:0];
        end
    end

    ibex_multdiv_issue_adder u_adder (
        .operand_a     (alu_operand_a_i),
        .operand_b     (alu_operand_b_i),
        .adder_ext     (alu_adder_ext_o),
        .adder         (alu_adder_o),
        .equal_to_zero (equal_to_zero_o)
    );

    assign rsp_result_o      = result_q;
    assign busy_cycles_o     = busy_q;
    assign operator_o        = operator_q;
    assign signed_mode_o     = signed_mode_q;
    assign op_a_o            = op_a_q;
    assign op_b_o            = op_b_q;
    assign data_ind_timing_o = data_ind_timing_q;
    assign imd_val_q_o       = {imd0_q, imd1_q};

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Directed bench for ibex_multdiv_issue; a small behavioural model stands in
// for the multdiv unit and answers after the unit's latency.
module tb_ibex_multdiv_issue;
    import ibex_multdiv_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_operator = 2'd0;
    logic [1:0]  req_signed_mode = 2'd0;
    logic [31:0] req_op_a = 32'd0;
    logic [31:0] req_op_b = 32'd0;
    logic        req_dit = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [5:0]  busy_cycles;
    logic        mult_en, div_en, mult_sel, div_sel;
    logic [1:0]  operator_q, signed_mode_q;
    logic [31:0] op_a_q, op_b_q;
    logic        dit_q;
    logic [32:0] alu_a = 33'd0;
    logic [32:0] alu_b = 33'd0;
    logic [33:0] adder_ext;
    logic [31:0] adder;
    logic        eq_zero;
    logic [67:0] imd_q;
    logic [67:0] imd_d = 68'd0;
    logic [1:0]  imd_we = 2'b00;
    logic        ready_id;
    logic [31:0] unit_result = 32'd0;
    logic        unit_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int unit_cnt = 0;

    ibex_multdiv_issue #(.CNT_W(6)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready),
        .req_operator_i        (req_operator),
        .req_signed_mode_i     (req_signed_mode),
        .req_op_a_i            (req_op_a),
        .req_op_b_i            (req_op_b),
        .req_data_ind_timing_i (req_dit),
        .rsp_valid_o           (rsp_valid),
        .rsp_ready_i           (rsp_ready),
        .rsp_result_o          (rsp_result),
        .busy_cycles_o         (busy_cycles),
        .mult_en_o             (mult_en),
        .div_en_o              (div_en),
        .mult_sel_o            (mult_sel),
        .div_sel_o             (div_sel),
        .operator_o            (operator_q),
        .signed_mode_o         (signed_mode_q),
        .op_a_o                (op_a_q),
        .op_b_o                (op_b_q),
        .data_ind_timing_o     (dit_q),
        .alu_operand_a_i       (alu_a),
        .alu_operand_b_i       (alu_b),
        .alu_adder_ext_o       (adder_ext),
        .alu_adder_o           (adder),
        .equal_to_zero_o       (eq_zero),
        .imd_val_q_o           (imd_q),
        .imd_val_d_i           (imd_d),
        .imd_val_we_i          (imd_we),
        .multdiv_ready_id_o    (ready_id),
        .multdiv_result_i      (unit_result),
        .valid_i               (unit_valid)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural RV32M result for the stand-in unit.
    function automatic logic [31:0] unit_compute(logic [1:0] op, logic [1:0] sm,
                                                 logic [31:0] a, logic [31:0] b);
        longint ax, bx, r;
        ax = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
        bx = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
        case (op)
            2'd0: begin r = ax * bx; return r[31:0]; end
            2'd1: begin r = ax * bx; return r[63:32]; end
            2'd2: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                r = ax / bx;
                return r[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                r = ax % bx;
                return r[31:0];
            end
        endcase
    endfunction

    function automatic int unit_latency(logic [1:0] op, logic [31:0] b, logic dit);
        if (op == 2'd0) return LAT_MUL;
        if (op == 2'd1) return LAT_MULH;
        if ((b == 32'd0) && !dit) return LAT_DIV0;
        return LAT_DIV;
    endfunction

    // Stand-in unit: only answers when the enable matching the operator is up.
    always @(negedge clk) begin
        if (rst || !((operator_q < 2'd2) ? (mult_en && mult_sel) : (div_en && div_sel))) begin
            unit_cnt   = 0;
            unit_valid = 1'b0;
        end else begin
            unit_cnt++;
            unit_valid  = (unit_cnt == unit_latency(operator_q, op_b_q, dit_q));
            unit_result = unit_compute(operator_q, signed_mode_q, op_a_q, op_b_q);
        end
    end

    // Presents a request and holds it until accepted at a rising edge.
    task automatic send_req(input logic [1:0] op, input logic [1:0] sm,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic dit, output bit ok);
        ok = 1'b0;
        req_operator    = op;
        req_signed_mode = sm;
        req_op_a        = a;
        req_op_b        = b;
        req_dit         = dit;
        req_valid       = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Counts BUSY cycles after the accept edge until the response shows up.
    task automatic wait_rsp(output logic [31:0] res, output int lat,
                            output int bc, output bit ok);
        ok  = 1'b0;
        lat = 0;
        res = 32'd0;
        bc  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok  = 1'b1;
                res = rsp_result;
                bc  = int'(busy_cycles);
                break;
            end
            lat++;
        end
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [1:0] sm,
                          input logic [31:0] a, input logic [31:0] b, input logic dit,
                          output logic [31:0] res, output int lat, output int bc,
                          output bit ok);
        bit ok_req, ok_rsp;
        send_req(op, sm, a, b, dit, ok_req);
        wait_rsp(res, lat, bc, ok_rsp);
        consume_rsp();
        ok = ok_req && ok_rsp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_result, busy_cycles} !== {1'b1, 1'b0, 32'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got rdy=%b vld=%b res=%h bc=%0d expected rdy=1 vld=0 res=0 bc=0",
                     req_ready, rsp_valid, rsp_result, busy_cycles);
        end
        checks++;
        if ({mult_en, div_en, mult_sel, div_sel, ready_id, operator_q, signed_mode_q,
             op_a_q, op_b_q, dit_q, imd_q} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_unit_side: got en=%b%b sel=%b%b rid=%b op=%h a=%h b=%h imd=%h expected all zero",
                     mult_en, div_en, mult_sel, div_sel, ready_id, operator_q, op_a_q, op_b_q, imd_q);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_adder();
        logic [32:0] va [3];
        logic [32:0] vb [3];
        logic [33:0] ve [3];
        logic [31:0] vs [3];
        logic        vz [3];
        va[0] = 33'h1_FFFF_FFFF; vb[0] = 33'h0_0000_0001; ve[0] = 34'h2_0000_0000; vs[0] = 32'h0000_0000; vz[0] = 1'b1;
        va[1] = 33'h0_0000_0002; vb[1] = 33'h0_0000_0004; ve[1] = 34'h0_0000_0006; vs[1] = 32'h0000_0003; vz[1] = 1'b0;
        va[2] = 33'h0_0000_0001; vb[2] = 33'h0_0000_0000; ve[2] = 34'h0_0000_0001; vs[2] = 32'h0000_0000; vz[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_a = va[i];
            alu_b = vb[i];
            #1;
            checks++;
            if ({adder_ext, adder, eq_zero} !== {ve[i], vs[i], vz[i]}) begin
                errors++;
                $display("[TB] FAIL adder_%0d: got ext=%h sum=%h z=%b expected ext=%h sum=%h z=%b",
                         i, adder_ext, adder, eq_zero, ve[i], vs[i], vz[i]);
            end
        end
    endtask

    task automatic test_imd();
        logic [67:0] vd  [3];
        logic [1:0]  vwe [3];
        logic [67:0] vq  [3];
        vd[0] = {34'h2_AAAA_5555, 34'h1_2345_6789}; vwe[0] = 2'b01; vq[0] = {34'h2_AAAA_5555, 34'h0};
        vd[1] = {34'h0_0000_0000, 34'h3_FFFF_0000}; vwe[1] = 2'b10; vq[1] = {34'h2_AAAA_5555, 34'h3_FFFF_0000};
        vd[2] = {34'h0_0000_0001, 34'h0_0000_0002}; vwe[2] = 2'b11; vq[2] = {34'h0_0000_0001, 34'h0_0000_0002};
        for (int i = 0; i < 3; i++) begin
            imd_d  = vd[i];
            imd_we = vwe[i];
            @(posedge clk);
            #1 imd_we = 2'b00;
            checks++;
            if (imd_q !== vq[i]) begin
                errors++;
                $display("[TB] FAIL imd_%0d: got %h expected %h", i, imd_q, vq[i]);
            end
        end
        // With we low the registers must keep their value.
        imd_d = 68'hF_FFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        checks++;
        if (imd_q !== vq[2]) begin
            errors++;
            $display("[TB] FAIL imd_hold: got %h expected %h", imd_q, vq[2]);
        end
    endtask

    // Shared vector runner for the op-level tests; each entry is hand-computed.
    task automatic test_ops(input string name, input int n,
                            input logic [1:0] op [8], input logic [1:0] sm [8],
                            input logic [31:0] a [8], input logic [31:0] b [8],
                            input logic dit [8], input logic [31:0] exp_res [8],
                            input int exp_lat [8]);
        logic [31:0] res;
        int lat, bc;
        bit ok;
        for (int i = 0; i < n; i++) begin
            run_op(op[i], sm[i], a[i], b[i], dit[i], res, lat, bc, ok);
            checks++;
            if (!ok || res !== exp_res[i]) begin
                errors++;
                $display("[TB] FAIL %s_%0d_result: got %h (ok=%0d) expected %h", name, i, res, ok, exp_res[i]);
            end
            checks++;
            if (lat != exp_lat[i] || bc != exp_lat[i]) begin
                errors++;
                $display("[TB] FAIL %s_%0d_latency: got lat=%0d busy=%0d expected %0d",
                         name, i, lat, bc, exp_lat[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [1:0] op [8]; logic [1:0] sm [8]; logic [31:0] a [8]; logic [31:0] b [8];
        logic dit [8]; logic [31:0] r [8]; int l [8];
        op = '{default: 2'd0}; sm = '{default: 2'd0}; a = '{default: 32'd0};
        b = '{default: 32'd0}; dit = '{default: 1'b0}; r = '{default: 32'd0}; l = '{default: 0};
        op[0] = 2'd0; sm[0] = 2'd0; a[0] = 32'd7;         b[0] = 32'd6; r[0] = 32'd42;         l[0] = 3;
        op[1] = 2'd0; sm[1] = 2'd3; a[1] = 32'hFFFF_FFFF; b[1] = 32'd5; r[1] = 32'hFFFF_FFFB; l[1] = 3;
        op[2] = 2'd1; sm[2] = 2'd0; a[2] = 32'hFFFF_FFFF; b[2] = 32'hFFFF_FFFF; r[2] = 32'hFFFF_FFFE; l[2] = 4;
        op[3] = 2'd1; sm[3] = 2'd3; a[3] = 32'hFFFF_FFFF; b[3] = 32'hFFFF_FFFF; r[3] = 32'h0000_0000; l[3] = 4;
        test_ops("mul", 4, op, sm, a, b, dit, r, l);
    endtask

    task automatic test_div();
        logic [1:0] op [8]; logic [1:0] sm [8]; logic [31:0] a [8]; logic [31:0] b [8];
        logic dit [8]; logic [31:0] r [8]; int l [8];
        op = '{default: 2'd0}; sm = '{default: 2'd0}; a = '{default: 32'd0};
        b = '{default: 32'd0}; dit = '{default: 1'b0}; r = '{default: 32'd0}; l = '{default: 0};
        op[0] = 2'd2; sm[0] = 2'd3; a[0] = 32'hFFFF_FFF9; b[0] = 32'd2;         r[0] = 32'hFFFF_FFFD; l[0] = 37;
        op[1] = 2'd3; sm[1] = 2'd3; a[1] = 32'hFFFF_FFF9; b[1] = 32'd2;         r[1] = 32'hFFFF_FFFF; l[1] = 37;
        op[2] = 2'd2; sm[2] = 2'd3; a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF; r[2] = 32'h8000_0000; l[2] = 37;
        op[3] = 2'd3; sm[3] = 2'd3; a[3] = 32'h8000_0000; b[3] = 32'hFFFF_FFFF; r[3] = 32'h0000_0000; l[3] = 37;
        test_ops("div", 4, op, sm, a, b, dit, r, l);
    endtask

    task automatic test_div_zero();
        logic [1:0] op [8]; logic [1:0] sm [8]; logic [31:0] a [8]; logic [31:0] b [8];
        logic dit [8]; logic [31:0] r [8]; int l [8];
        op = '{default: 2'd0}; sm = '{default: 2'd0}; a = '{default: 32'd0};
        b = '{default: 32'd0}; dit = '{default: 1'b0}; r = '{default: 32'd0}; l = '{default: 0};
        op[0] = 2'd2; a[0] = 32'h1234; dit[0] = 1'b0; r[0] = 32'hFFFF_FFFF; l[0] = 2;
        op[1] = 2'd3; a[1] = 32'h1234; dit[1] = 1'b0; r[1] = 32'h0000_1234; l[1] = 2;
        op[2] = 2'd2; a[2] = 32'h1234; dit[2] = 1'b1; r[2] = 32'hFFFF_FFFF; l[2] = 37;
        test_ops("divzero", 3, op, sm, a, b, dit, r, l);
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bc;
        bit ok_req, ok_rsp;
        send_req(2'd0, 2'd0, 32'd11, 32'd3, 1'b0, ok_req);
        wait_rsp(res, lat, bc, ok_rsp);
        checks++;
        if (!ok_req || !ok_rsp || res !== 32'd33) begin
            errors++;
            $display("[TB] FAIL stall_first_result: got %h (ok=%0d%0d) expected 00000021", res, ok_req, ok_rsp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_result, req_ready, mult_en, div_en, mult_sel, div_sel, ready_id}
                !== {1'b1, 32'd33, 1'b0, 5'b00000}) begin
                errors++;
                $display("[TB] FAIL stall_cycle_%0d: got vld=%b res=%h rdy=%b en=%b%b sel=%b%b rid=%b expected vld=1 res=00000021 rdy=0 unit idle",
                         i, rsp_valid, rsp_result, req_ready, mult_en, div_en, mult_sel, div_sel, ready_id);
            end
        end
        // Release the response and present the next request in the same cycle.
        rsp_ready       = 1'b1;
        req_operator    = 2'd0;
        req_signed_mode = 2'd0;
        req_op_a        = 32'd5;
        req_op_b        = 32'd4;
        req_dit         = 1'b0;
        req_valid       = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release_ready: got %b expected 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        wait_rsp(res, lat, bc, ok_rsp);
        checks++;
        if (!ok_rsp || res !== 32'd20 || lat != 3 || bc != 3) begin
            errors++;
            $display("[TB] FAIL back_to_back_result: got %h lat=%0d busy=%0d (ok=%0d) expected 00000014 lat=3 busy=3",
                     res, lat, bc, ok_rsp);
        end
        consume_rsp();
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        int lat, bc;
        bit ok;
        send_req(2'd2, 2'd3, 32'd100, 32'd7, 1'b0, ok);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_result, busy_cycles} !== {1'b1, 1'b0, 32'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL midop_reset_handshake: got rdy=%b vld=%b res=%h bc=%0d expected rdy=1 vld=0 res=0 bc=0",
                     req_ready, rsp_valid, rsp_result, busy_cycles);
        end
        checks++;
        if ({mult_en, div_en, mult_sel, div_sel, ready_id, operator_q, signed_mode_q,
             op_a_q, op_b_q, dit_q, imd_q} !== '0) begin
            errors++;
            $display("[TB] FAIL midop_reset_unit_side: got en=%b%b sel=%b%b rid=%b op=%h a=%h b=%h imd=%h expected all zero",
                     mult_en, div_en, mult_sel, div_sel, ready_id, operator_q, op_a_q, op_b_q, imd_q);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(2'd0, 2'd0, 32'd3, 32'd3, 1'b0, res, lat, bc, ok);
        checks++;
        if (!ok || res !== 32'd9 || lat != 3 || bc != 3) begin
            errors++;
            $display("[TB] FAIL after_reset_mul: got %h lat=%0d busy=%0d (ok=%0d) expected 00000009 lat=3 busy=3",
                     res, lat, bc, ok);
        end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        test_reset();
        test_adder();
        test_imd();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
